mem_wb_stage: RTL and testbench

//  Elastic MEM->WB pipeline stage for the RV32 core. Replaces the fixed MEM/WB register with a

---
 rtl/mem_wb_stage_if.sv | 40 ++++
 rtl/mem_wb_stage.sv | 136 +++++++++++++
 tb/tb_mem_wb_stage.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_wb_stage_if.sv
// Bus between the MEM stage, the MEM->WB elastic stage and the register-file
// write port.
//   slave  : the stage's view (takes the MEM-side instruction, drives write-back)
//   master : the environment's view (drives the instruction, takes write-back)
// Upstream  : in_valid/in_ready handshake, pc_4, mem_to_reg, reg_write, jalr,
//             funct3, write_register, alu_result, read_mem_data
// Downstream: out_valid/out_ready handshake, wb_we, wb_rd, wb_data, retire_count
interface mem_wb_stage_if #(
  parameter int N    = 32,
  parameter int RA_W = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [N-1:0]    pc_4;
  logic            mem_to_reg;
  logic            reg_write;
  logic            jalr;
  logic [2:0]      funct3;
  logic [RA_W-1:0] write_register;
  logic [N-1:0]    alu_result;
  logic [N-1:0]    read_mem_data;
  logic            out_ready;
  logic            out_valid;
  logic            wb_we;
  logic [RA_W-1:0] wb_rd;
  logic [N-1:0]    wb_data;
  logic [N-1:0]    retire_count;

  modport slave (
    input  in_valid, pc_4, mem_to_reg, reg_write, jalr, funct3,
           write_register, alu_result, read_mem_data, out_ready,
    output in_ready, out_valid, wb_we, wb_rd, wb_data, retire_count
  );

  modport master (
    output in_valid, pc_4, mem_to_reg, reg_write, jalr, funct3,
           write_register, alu_result, read_mem_data, out_ready,
    input  in_ready, out_valid, wb_we, wb_rd, wb_data, retire_count
  );
endinterface

// File: rtl/mem_wb_stage.sv
// Elastic MEM->WB pipeline stage: valid/ready output register backed by a
// 1-entry skid buffer, with flush, load-data alignment, write-back source
// selection and a retired-instruction counter.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high; clears all state
//   flush : drop output register and skid contents at the next edge
//   bus   : mem_wb_stage_if.slave (upstream instruction, downstream write-back)
module mem_wb_stage #(
  parameter int N          = 32,
  parameter int RA_W       = 5,
  parameter int LOAD_ALIGN = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flush,
  mem_wb_stage_if.slave  bus
);

  typedef struct packed {
    logic [N-1:0]    pc_4;
    logic [N-1:0]    alu_result;
    logic [N-1:0]    load_data;
    logic            mem_to_reg;
    logic            reg_write;
    logic            jalr;
    logic [RA_W-1:0] rd;
  } entry_t;

  entry_t          out_q, out_d;
  entry_t          skid_q, skid_d;
  entry_t          in_entry;
  logic            out_valid_q, out_valid_d;
  logic            skid_valid_q, skid_valid_d;
  logic [N-1:0]    retire_count_q, retire_count_d;
  logic [N-1:0]    load_aligned;
  logic            accept;
  logic            retire;

  // Loads are aligned on entry so both storage slots hold final load data.
  if (LOAD_ALIGN != 0) begin : g_align
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
      case (bus.alu_result[1:0])
        2'd0:    byte_sel = bus.read_mem_data[7:0];
        2'd1:    byte_sel = bus.read_mem_data[15:8];
        2'd2:    byte_sel = bus.read_mem_data[23:16];
        default: byte_sel = bus.read_mem_data[31:24];
      endcase
      half_sel = bus.alu_result[1] ? bus.read_mem_data[31:16]
                                   : bus.read_mem_data[15:0];
      case (bus.funct3)
        3'b000:  load_aligned = {{24{byte_sel[7]}}, byte_sel};
        3'b100:  load_aligned = {24'h0, byte_sel};
        3'b001:  load_aligned = {{16{half_sel[15]}}, half_sel};
        3'b101:  load_aligned = {16'h0, half_sel};
        default: load_aligned = bus.read_mem_data;
      endcase
    end
  end else begin : g_raw
    assign load_aligned = bus.read_mem_data;
  end

  always_comb begin
    in_entry            = '0;
    in_entry.pc_4       = bus.pc_4;
    in_entry.alu_result = bus.alu_result;
    in_entry.load_data  = load_aligned;
    in_entry.mem_to_reg = bus.mem_to_reg;
    in_entry.reg_write  = bus.reg_write;
    in_entry.jalr       = bus.jalr;
    in_entry.rd         = bus.write_register;
  end

  assign bus.in_ready = ~skid_valid_q;
  assign accept       = bus.in_valid & ~skid_valid_q;
  assign retire       = out_valid_q & bus.out_ready;

  always_comb begin
    out_d          = out_q;
    skid_d         = skid_q;
    out_valid_d    = out_valid_q;
    skid_valid_d   = skid_valid_q;
    retire_count_d = retire_count_q + {{(N-1){1'b0}}, retire};

    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || retire) begin
      if (skid_valid_q) begin
        // Skid drains first to keep order; skid refills only on a new accept.
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = accept;
        if (accept) skid_d = in_entry;
      end else begin
        if (accept) out_d = in_entry;
        out_valid_d = accept;
      end
    end else if (accept) begin
      skid_d       = in_entry;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q          <= '0;
      skid_q         <= '0;
      out_valid_q    <= 1'b0;
      skid_valid_q   <= 1'b0;
      retire_count_q <= '0;
    end else begin
      out_q          <= out_d;
      skid_q         <= skid_d;
      out_valid_q    <= out_valid_d;
      skid_valid_q   <= skid_valid_d;
      retire_count_q <= retire_count_d;
    end
  end

  // jalr link has priority over load data.
  always_comb begin
    if (out_q.jalr)            bus.wb_data = out_q.pc_4;
    else if (out_q.mem_to_reg) bus.wb_data = out_q.load_data;
    else                       bus.wb_data = out_q.alu_result;
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.wb_rd        = out_q.rd;
  assign bus.wb_we        = out_valid_q & out_q.reg_write & (|out_q.rd);
  assign bus.retire_count = retire_count_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

  logic clk = 1'b0;
  logic reset;
  logic flush;

  always #5 clk = ~clk;

  mem_wb_stage_if #(.N(32), .RA_W(5)) bus ();
  mem_wb_stage_if #(.N(8),  .RA_W(5)) bus8 ();

  mem_wb_stage #(.N(32), .RA_W(5), .LOAD_ALIGN(1)) dut (
    .clk(clk), .reset(reset), .flush(flush), .bus(bus)
  );

  mem_wb_stage #(.N(8), .RA_W(5), .LOAD_ALIGN(0)) dut8 (
    .clk(clk), .reset(reset), .flush(1'b0), .bus(bus8)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
  } exp_t;

  exp_t        q[$];
  logic [31:0] rc_model;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Write-back value straight from the instruction semantics.
  function automatic logic [31:0] ref_wb(input logic jalr, input logic m2r,
                                         input logic [31:0] pc4, input logic [31:0] alu,
                                         input logic [31:0] word, input logic [2:0] f3);
    int unsigned a, b, h;
    if (jalr) return pc4;
    if (!m2r) return alu;
    a = alu % 4;
    b = (word >> (8 * a)) & 32'hFF;
    h = (word >> (16 * (a / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFFFF00 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF0000 : h;
      3'd5:    return h;
      default: return word;
    endcase
  endfunction

  // One clock: check outputs against the occupancy queue, then advance it.
  task automatic cycle();
    logic acc, ret;
    exp_t e;
    #3;
    chk("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
    chk("in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
    chk("retire_count", bus.retire_count, rc_model);
    if (q.size() > 0) begin
      chk("wb_data", bus.wb_data, q[0].data);
      chk("wb_rd", 32'(bus.wb_rd), 32'(q[0].rd));
      chk("wb_we", 32'(bus.wb_we), 32'(q[0].we));
    end else begin
      chk("wb_we_idle", 32'(bus.wb_we), 32'd0);
    end
    acc    = bus.in_valid && (q.size() < 2);
    ret    = bus.out_ready && (q.size() > 0);
    e.data = ref_wb(bus.jalr, bus.mem_to_reg, bus.pc_4, bus.alu_result,
                    bus.read_mem_data, bus.funct3);
    e.rd   = bus.write_register;
    e.we   = bus.reg_write && (bus.write_register != 5'd0);
    @(posedge clk);
    if (ret) begin
      void'(q.pop_front());
      rc_model = rc_model + 32'd1;
    end
    if (flush) q.delete();
    else if (acc) q.push_back(e);
    #1;
  endtask

  task automatic set_instr(input logic v, input logic [2:0] f3, input logic jalr,
                           input logic m2r, input logic rw, input logic [4:0] rd,
                           input logic [31:0] pc4, input logic [31:0] alu,
                           input logic [31:0] word);
    bus.in_valid       = v;
    bus.funct3         = f3;
    bus.jalr           = jalr;
    bus.mem_to_reg     = m2r;
    bus.reg_write      = rw;
    bus.write_register = rd;
    bus.pc_4           = pc4;
    bus.alu_result     = alu;
    bus.read_mem_data  = word;
  endtask

  task automatic rand_instr();
    set_instr(($urandom % 4) != 0, 3'($urandom % 8), ($urandom % 5) == 0,
              ($urandom % 2) == 1, ($urandom % 4) != 0,
              (($urandom % 4) == 0) ? 5'd0 : 5'($urandom % 32),
              $urandom, $urandom, $urandom);
    bus.out_ready = ($urandom % 3) != 0;
    flush         = ($urandom % 20) == 0;
  endtask

  task automatic load_case(input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] expv, input string tag);
    set_instr(1'b1, f3, 1'b0, 1'b1, 1'b1, 5'd7, 32'h0, addr, 32'h80FF7F01);
    bus.out_ready = 1'b1;
    cycle();
    chk(tag, bus.wb_data, expv);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    set_instr(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 5'd0, '0, '0, '0);
    bus.out_ready       = 1'b1;
    bus8.in_valid       = 1'b0;
    bus8.out_ready      = 1'b1;
    bus8.pc_4           = 8'h0;
    bus8.mem_to_reg     = 1'b0;
    bus8.reg_write      = 1'b1;
    bus8.jalr           = 1'b0;
    bus8.funct3         = 3'd2;
    bus8.write_register = 5'd1;
    bus8.alu_result     = 8'h5A;
    bus8.read_mem_data  = 8'h0;
    rc_model = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_retire_count", bus.retire_count, 32'd0);
    chk("rst_wb_data", bus.wb_data, 32'd0);
    chk("rst_wb_we", 32'(bus.wb_we), 32'd0);
    chk("rst_wb_rd", 32'(bus.wb_rd), 32'd0);
    chk("rst_retire_count8", 32'(bus8.retire_count), 32'd0);
    reset = 1'b0;

    // In-order stream of four, always ready.
    for (int i = 0; i < 4; i++) begin
      set_instr(1'b1, 3'd2, 1'b0, 1'b0, 1'b1, 5'(i + 1), 32'h100 + 32'(4 * i),
                32'hA000 + 32'(i), 32'h0);
      cycle();
    end
    bus.in_valid = 1'b0;
    cycle();
    chk("stream_retire_count", bus.retire_count, 32'd4);

    // Backpressure: A in output, B in skid, C refused.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_instr(1'b1, 3'd2, 1'b0, 1'b0, 1'b1, 5'(10 + i), 32'h0,
                32'hB000 + 32'(i), 32'h0);
      cycle();
      if (i == 1) chk("skid_full_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) cycle();

    // Load alignment on word 0x80FF7F01.
    load_case(3'd0, 32'd2, 32'hFFFFFFFF, "lb_a2");
    load_case(3'd0, 32'd3, 32'hFFFFFF80, "lb_a3");
    load_case(3'd5, 32'd2, 32'h000080FF, "lhu_a2");
    load_case(3'd1, 32'd0, 32'h00007F01, "lh_a0");
    load_case(3'd4, 32'd1, 32'h0000007F, "lbu_a1");
    cycle();

    // jalr beats mem_to_reg; rd=0 never writes.
    set_instr(1'b1, 3'd0, 1'b1, 1'b1, 1'b1, 5'd0, 32'h104, 32'h2, 32'h80FF7F01);
    cycle();
    chk("jalr_wb_data", bus.wb_data, 32'h104);
    chk("rd0_wb_we", 32'(bus.wb_we), 32'd0);
    bus.in_valid = 1'b0;
    cycle();

    // Flush with skid full.
    bus.out_ready = 1'b0;
    set_instr(1'b1, 3'd2, 1'b0, 1'b0, 1'b1, 5'd3, 32'h0, 32'hC0, 32'h0);
    repeat (2) cycle();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b1;
    cycle();

    // Asynchronous reset with skid full.
    bus.out_ready = 1'b0;
    set_instr(1'b1, 3'd2, 1'b0, 1'b0, 1'b1, 5'd4, 32'h0, 32'hD0, 32'h0);
    repeat (2) cycle();
    reset = 1'b1;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("arst_retire_count", bus.retire_count, 32'd0);
    chk("arst_wb_we", 32'(bus.wb_we), 32'd0);
    q.delete();
    rc_model = 32'd0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    cycle();

    // Randomized traffic against the occupancy model.
    for (int i = 0; i < 400; i++) begin
      rand_instr();
      cycle();
    end
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) cycle();

    // Counter wrap on the 8-bit instance: continuous stream, 1 retire per edge.
    bus8.in_valid  = 1'b1;
    bus8.out_ready = 1'b1;
    for (int k = 1; k <= 257; k++) begin
      @(posedge clk);
      #1;
      if (k == 256) chk("wrap_max", 32'(bus8.retire_count), 32'd255);
      if (k == 257) chk("wrap_zero", 32'(bus8.retire_count), 32'd0);
    end
    bus8.in_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
